// File: rtl/cursor_select_ctrl_if.sv
// Button/cursor bundle between the raw push-buttons, the cursor controller and the game core.
// Latency: none (pure signal bundle).
// Backpressure: none; buttons are levels and the core consumes one-cycle strobes unconditionally.
// Ports: BtnU/BtnD/BtnL/BtnR/BtnC raw buttons, play_en game-state qualifier,
//        Row/Col cursor position, down_button place strobe, center_button start/confirm strobe.
interface cursor_select_ctrl_if;
  logic       BtnU;
  logic       BtnD;
  logic       BtnL;
  logic       BtnR;
  logic       BtnC;
  logic       play_en;
  logic [7:0] Row;
  logic [7:0] Col;
  logic       down_button;
  logic       center_button;

  // master: board/core side (drives buttons and play_en, receives cursor and strobes)
  modport master (
    output BtnU, BtnD, BtnL, BtnR, BtnC, play_en,
    input  Row, Col, down_button, center_button
  );

  // slave: the cursor controller
  modport slave (
    input  BtnU, BtnD, BtnL, BtnR, BtnC, play_en,
    output Row, Col, down_button, center_button
  );
endinterface

// File: rtl/cursor_select_ctrl.sv
// Synchronises/debounces five board buttons and moves an 8x8 cursor; emits place/start strobes.
// Latency: raw edge to Row/Col/strobe change is DEBOUNCE_CYCLES+5 clk cycles; all outputs registered.
// Backpressure: none; every accepted press is acted on immediately, held buttons give one pulse.
// Ports: clk, reset_n (async active-low), sel (slave side of cursor_select_ctrl_if).
module cursor_select_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GRID_MAX        = 8,
  parameter int ROW_INIT        = 4,
  parameter int COL_INIT        = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  cursor_select_ctrl_if.slave    sel
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int NB = 5;
  // bit positions in the button vectors
  localparam int IU = 0;
  localparam int ID = 1;
  localparam int IL = 2;
  localparam int IR = 3;
  localparam int IC = 4;

  typedef enum logic [2:0] {
    IDLE,
    CHK_PRESS,
    PRESSED,
    HELD,
    CHK_REL
  } db_state_t;

  logic [NB-1:0] raw;
  logic [NB-1:0] sync_a;
  logic [NB-1:0] sync_b;
  logic [NB-1:0] press;
  db_state_t     state [NB];
  logic [CW-1:0] cnt   [NB];

  logic [7:0] row_q;
  logic [7:0] col_q;
  logic       down_q;
  logic       center_q;

  assign raw = {sel.BtnC, sel.BtnR, sel.BtnL, sel.BtnD, sel.BtnU};

  // 2-FF synchronisers; buttons are fully asynchronous to clk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // One debounce FSM per button. press[i] is registered from the PRESSED state, so it
  // rises the cycle after PRESSED is entered and is high for exactly one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      press <= '0;
      for (int i = 0; i < NB; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        press[i] <= 1'b0;
        case (state[i])
          IDLE: begin
            if (sync_b[i]) begin
              state[i] <= CHK_PRESS;
              cnt[i]   <= CW'(1);
            end
          end
          CHK_PRESS: begin
            if (!sync_b[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else if (cnt[i] == CW'(DEBOUNCE_CYCLES)) begin
              state[i] <= PRESSED;
              cnt[i]   <= '0;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
          PRESSED: begin
            press[i] <= 1'b1;
            state[i] <= HELD;
          end
          HELD: begin
            if (!sync_b[i]) begin
              state[i] <= CHK_REL;
              cnt[i]   <= CW'(1);
            end
          end
          CHK_REL: begin
            if (sync_b[i]) begin
              state[i] <= HELD;
              cnt[i]   <= '0;
            end else if (cnt[i] == CW'(DEBOUNCE_CYCLES)) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
          default: begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  // Cursor and strobes. A centre press takes priority: the cursor is frozen in the
  // cycle the core samples down_button, so coincident move pulses are dropped.
  // Opposing pulses on one axis cancel; the two axes are independent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q    <= 8'(ROW_INIT);
      col_q    <= 8'(COL_INIT);
      down_q   <= 1'b0;
      center_q <= 1'b0;
    end else begin
      center_q <= press[IC];
      down_q   <= press[IC] & sel.play_en;
      if (!press[IC] && sel.play_en) begin
        if (press[IU] && !press[ID] && (row_q > 8'd1)) begin
          row_q <= row_q - 8'd1;
        end else if (press[ID] && !press[IU] && (row_q < 8'(GRID_MAX))) begin
          row_q <= row_q + 8'd1;
        end
        if (press[IL] && !press[IR] && (col_q > 8'd1)) begin
          col_q <= col_q - 8'd1;
        end else if (press[IR] && !press[IL] && (col_q < 8'(GRID_MAX))) begin
          col_q <= col_q + 8'd1;
        end
      end
    end
  end

  assign sel.Row           = row_q;
  assign sel.Col           = col_q;
  assign sel.down_button   = down_q;
  assign sel.center_button = center_q;

endmodule
